// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART TX flow scheduler.
package uart_pkg;
    localparam logic [7:0] XON_CHAR  = 8'h11;
    localparam logic [7:0] XOFF_CHAR = 8'h13;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;
endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the search starts at the pointer,
// which moves just past the winner whenever a grant is consumed.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        int idx;
        idx    = 0;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_flow_scheduler.sv
// Shares one UART TX path between NUM_REQ byte sources and applies CTS gating,
// RTS hysteresis and XON/XOFF insertion on TX plus XON/XOFF stripping on RX.
module uart_tx_flow_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int LVL_W      = 5,
    parameter int HIGH_WM    = 24,
    parameter int LOW_WM     = 8,
    parameter int SW_FLOW_EN = 1,
    parameter int HW_FLOW_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    input  logic                       cts,
    output logic                       rts,
    input  logic [LVL_W-1:0]           rx_level,
    input  logic                       rx_byte_valid,
    input  logic [7:0]                 rx_byte,
    output logic                       rx_out_valid,
    output logic [7:0]                 rx_out_data,
    output logic                       paused
);
    import uart_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(HIGH_WM);
    localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_WM);

    tx_state_t state, state_nxt;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic [7:0]         data_byte;

    logic can_launch;
    logic sel_xoff, sel_xon, sel_data, launch;
    logic rts_fall, rts_rise;
    logic xoff_pend, xon_pend, xoff_sent;
    logic xoff_pend_nxt, xon_pend_nxt, xoff_sent_nxt;

    uart_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid & {NUM_REQ{!paused}}),
        .advance(sel_data),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign data_byte  = req_data[int'(arb_id)*8 +: 8];
    assign can_launch = !((HW_FLOW_EN != 0) && !cts);
    assign tx_start   = (state == LAUNCH);
    assign rts_fall   = rts && (rx_level >= HIGH_LVL);
    assign rts_rise   = !rts && (rx_level <= LOW_LVL);

    // Control characters outrank data and are not held back by paused.
    always_comb begin
        sel_xoff = 1'b0;
        sel_xon  = 1'b0;
        sel_data = 1'b0;
        if (state == IDLE && can_launch) begin
            if (xoff_pend)
                sel_xoff = 1'b1;
            else if (xon_pend)
                sel_xon = 1'b1;
            else if (arb_any)
                sel_data = 1'b1;
        end
        launch = sel_xoff || sel_xon || sel_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (launch) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = tx_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data   <= '0;
            req_ready <= '0;
            grant_id  <= '0;
        end else begin
            req_ready <= sel_data ? arb_gnt : '0;
            if (sel_xoff) begin
                tx_data <= XOFF_CHAR;
            end else if (sel_xon) begin
                tx_data <= XON_CHAR;
            end else if (sel_data) begin
                tx_data  <= data_byte;
                grant_id <= arb_id;
            end
        end
    end

    // Launch effects apply first so an rts edge in the same cycle sees the
    // updated xoff_sent; an opposite edge before launch cancels the pending char.
    always_comb begin
        xoff_pend_nxt = xoff_pend;
        xon_pend_nxt  = xon_pend;
        xoff_sent_nxt = xoff_sent;
        if (sel_xoff) begin
            xoff_pend_nxt = 1'b0;
            xoff_sent_nxt = 1'b1;
        end
        if (sel_xon) begin
            xon_pend_nxt  = 1'b0;
            xoff_sent_nxt = 1'b0;
        end
        if (SW_FLOW_EN != 0) begin
            if (rts_fall) begin
                if (xon_pend_nxt)
                    xon_pend_nxt = 1'b0;
                else if (!xoff_sent_nxt)
                    xoff_pend_nxt = 1'b1;
            end
            if (rts_rise) begin
                if (xoff_pend_nxt)
                    xoff_pend_nxt = 1'b0;
                else if (xoff_sent_nxt)
                    xon_pend_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rts       <= 1'b1;
            xoff_pend <= 1'b0;
            xon_pend  <= 1'b0;
            xoff_sent <= 1'b0;
        end else begin
            if (rts_fall)
                rts <= 1'b0;
            else if (rts_rise)
                rts <= 1'b1;
            xoff_pend <= xoff_pend_nxt;
            xon_pend  <= xon_pend_nxt;
            xoff_sent <= xoff_sent_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paused       <= 1'b0;
            rx_out_valid <= 1'b0;
            rx_out_data  <= '0;
        end else begin
            rx_out_valid <= 1'b0;
            if (rx_byte_valid) begin
                if ((SW_FLOW_EN != 0) && rx_byte == XOFF_CHAR) begin
                    paused <= 1'b1;
                end else if ((SW_FLOW_EN != 0) && rx_byte == XON_CHAR) begin
                    paused <= 1'b0;
                end else begin
                    rx_out_valid <= 1'b1;
                    rx_out_data  <= rx_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_flow_scheduler.sv
// Directed bench for uart_tx_flow_scheduler: arbitration, CTS gating, XON/XOFF
// insertion and stripping, and mid-frame reset; a second instance has SW flow off.
`timescale 1ns/1ps
module tb_uart_tx_flow_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [31:0] req_data;
    logic [3:0] req_ready;
    logic [1:0] grant_id;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       cts;
    logic       rts;
    logic [4:0] rx_level;
    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic       rx_out_valid;
    logic [7:0] rx_out_data;
    logic       paused;

    logic [3:0] req_ready1;
    logic [1:0] grant_id1;
    logic       tx_start1;
    logic [7:0] tx_data1;
    logic       rts1;
    logic [4:0] rx_level1;
    logic       rx_byte_valid1;
    logic [7:0] rx_byte1;
    logic       rx_out_valid1;
    logic [7:0] rx_out_data1;
    logic       paused1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx_flow_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .cts(cts), .rts(rts), .rx_level(rx_level),
        .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_out_valid(rx_out_valid),
        .rx_out_data(rx_out_data), .paused(paused)
    );

    uart_tx_flow_scheduler #(.SW_FLOW_EN(0)) dut_nosw (
        .clk(clk), .reset(reset), .req_valid(4'b0000), .req_data(32'h0),
        .req_ready(req_ready1), .grant_id(grant_id1), .tx_start(tx_start1), .tx_data(tx_data1),
        .tx_busy(1'b0), .cts(1'b1), .rts(rts1), .rx_level(rx_level1),
        .rx_byte_valid(rx_byte_valid1), .rx_byte(rx_byte1), .rx_out_valid(rx_out_valid1),
        .rx_out_data(rx_out_data1), .paused(paused1)
    );

    // Transmitter model: busy for 10 cycles starting the edge after tx_start.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start)
            busy_cnt <= 10;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    logic [7:0] lq[$];
    logic [1:0] gq[$];
    logic [3:0] rq[$];
    int ready_pulses = 0;
    int starts1 = 0;

    always @(negedge clk) begin
        if (tx_start) begin
            lq.push_back(tx_data);
            gq.push_back(grant_id);
            rq.push_back(req_ready);
        end
        if (req_ready != 4'b0000)
            ready_pulses++;
        if (tx_start1)
            starts1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        tick(1);
        rx_byte_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int cnt;
        cnt = 0;
        while (lq.size() < n && cnt < budget) begin
            tick(1);
            cnt++;
        end
        check(tag, lq.size(), n);
    endtask

    task automatic clear_log();
        lq.delete();
        gq.delete();
        rq.delete();
        ready_pulses = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_data[4];
        logic [1:0] exp_gnt[4];
        logic [3:0] exp_rdy[4];
        int base1;
        exp_data = '{8'hA0, 8'hA1, 8'hA3, 8'hA0};
        exp_gnt  = '{2'd0, 2'd1, 2'd3, 2'd0};
        exp_rdy  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

        reset = 1'b1;
        req_valid = 4'b0000;
        req_data = 32'hA3A2A1A0;
        cts = 1'b1;
        rx_level = '0;
        rx_byte_valid = 1'b0;
        rx_byte = '0;
        rx_level1 = '0;
        rx_byte_valid1 = 1'b0;
        rx_byte1 = '0;
        #2;
        reset = 1'b0;
        tick(3);

        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_rts", rts, 1);
        check("rst_paused", paused, 0);
        check("rst_rx_out_valid", rx_out_valid, 0);
        reset = 1'b1;
        tick(2);

        // Round-robin over requesters 0,1,3
        clear_log();
        req_valid = 4'b1011;
        wait_starts(4, 200, "rr_launches");
        req_valid = 4'b0000;
        tick(30);
        check("rr_total", lq.size(), 4);
        check("rr_ready_pulses", ready_pulses, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < lq.size()) begin
                check($sformatf("rr_data%0d", i), lq[i], exp_data[i]);
                check($sformatf("rr_gnt%0d", i), gq[i], exp_gnt[i]);
                check($sformatf("rr_rdy%0d", i), rq[i], exp_rdy[i]);
            end
        end

        // Reset asserted while a frame is in flight
        clear_log();
        req_valid = 4'b0001;
        wait_starts(1, 50, "mf_launch");
        req_valid = 4'b0000;
        tick(2);
        pulse_rx(8'h13);
        rx_level = 5'd24;
        tick(1);
        check("mf_paused_before", paused, 1);
        check("mf_rts_before", rts, 0);
        reset = 1'b0;
        rx_level = '0;
        #1;
        check("mf_rts", rts, 1);
        check("mf_tx_start", tx_start, 0);
        check("mf_paused", paused, 0);
        check("mf_req_ready", req_ready, 0);
        check("mf_grant_id", grant_id, 0);
        tick(2);
        reset = 1'b1;
        tick(40);
        check("mf_no_ctrl_after", lq.size(), 1);

        // XOFF/XON from far end
        clear_log();
        pulse_rx(8'h13);
        check("pause_set", paused, 1);
        check("pause_stripped", rx_out_valid, 0);
        req_valid = 4'b0100;
        tick(20);
        check("pause_hold", lq.size(), 0);
        pulse_rx(8'h11);
        check("resume_clear", paused, 0);
        check("resume_stripped", rx_out_valid, 0);
        check("resume_not_yet", tx_start, 0);
        tick(1);
        check("resume_tx_start", tx_start, 1);
        check("resume_tx_data", tx_data, 8'hA2);
        check("resume_grant", grant_id, 2);
        req_valid = 4'b0000;
        pulse_rx(8'h41);
        check("rx_pass_valid", rx_out_valid, 1);
        check("rx_pass_data", rx_out_data, 8'h41);
        tick(1);
        check("rx_pass_pulse", rx_out_valid, 0);
        tick(20);

        // Local watermarks drive rts and XOFF/XON insertion
        clear_log();
        req_valid = 4'b0010;
        wait_starts(1, 50, "wm_first");
        rx_level = 5'd23;
        tick(1);
        check("wm_rts_23", rts, 1);
        rx_level = 5'd24;
        tick(1);
        check("wm_rts_24", rts, 0);
        wait_starts(3, 100, "wm_seq");
        req_valid = 4'b0000;
        if (lq.size() >= 3) begin
            check("wm_xoff_first", lq[1], 8'h13);
            check("wm_data_after", lq[2], 8'hA1);
        end
        rx_level = 5'd9;
        tick(3);
        check("wm_rts_hold9", rts, 0);
        rx_level = 5'd24;
        tick(40);
        check("wm_xoff_once", lq.size(), 3);
        rx_level = 5'd8;
        tick(1);
        check("wm_rts_8", rts, 1);
        wait_starts(4, 50, "wm_xon_launch");
        if (lq.size() >= 4)
            check("wm_xon_char", lq[3], 8'h11);
        rx_level = '0;
        tick(20);

        // Level crosses both ways during a frame: nothing extra is sent
        clear_log();
        req_valid = 4'b0001;
        wait_starts(1, 50, "cancel_launch");
        req_valid = 4'b0000;
        rx_level = 5'd24;
        tick(1);
        rx_level = 5'd8;
        tick(1);
        check("cancel_rts", rts, 1);
        tick(30);
        check("cancel_no_ctrl", lq.size(), 1);
        rx_level = '0;

        // CTS gating
        clear_log();
        cts = 1'b0;
        req_valid = 4'b1000;
        tick(50);
        check("cts_block", lq.size(), 0);
        cts = 1'b1;
        tick(1);
        check("cts_release_start", tx_start, 1);
        check("cts_release_data", tx_data, 8'hA3);
        req_valid = 4'b0000;
        tick(20);

        // Software flow control disabled
        rx_byte1 = 8'h13;
        rx_byte_valid1 = 1'b1;
        tick(1);
        rx_byte_valid1 = 1'b0;
        check("nosw_pass_valid", rx_out_valid1, 1);
        check("nosw_pass_data", rx_out_data1, 8'h13);
        check("nosw_paused", paused1, 0);
        base1 = starts1;
        rx_level1 = 5'd24;
        tick(30);
        check("nosw_rts", rts1, 0);
        check("nosw_no_xoff", starts1 - base1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
